fighter_player: RTL and testbench



---
 rtl/fighter_pkg.sv | 43 ++++
 rtl/fighter_turn_strobe.sv | 29 ++
 rtl/fighter_player.sv | 144 ++++++++++++++
 tb/tb_fighter_player.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fighter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fighter_pkg
// Purpose  : Action codes and position/health helpers shared by both players
//            and the game top level.
// Revision : 1.0
// ============================================================================
package fighter_pkg;

    typedef enum logic [2:0] {
        ACT_KICK   = 3'd0,
        ACT_PUNCH  = 3'd1,
        ACT_WAIT   = 3'd2,
        ACT_JUMP   = 3'd3,
        ACT_LEFT1  = 3'd4,
        ACT_LEFT2  = 3'd5,
        ACT_RIGHT1 = 3'd6,
        ACT_RIGHT2 = 3'd7
    } action_e;

    localparam int ACTION_W = 3;

    function automatic int home_cell(input int side, input int num_pos);
        return (side == 0) ? 0 : num_pos - 1;
    endfunction

    // Step a cell index by delta, clamped to the arena edges.
    function automatic int sat_add(input int p, input int delta, input int num_pos);
        int r;
        r = p + delta;
        if (r < 0)
            r = 0;
        else if (r > num_pos - 1)
            r = num_pos - 1;
        return r;
    endfunction

    function automatic int sat_sub(input int a, input int b);
        return (a > b) ? a - b : 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fighter_turn_strobe.sv
`default_nettype none
// ============================================================================
// Module   : fighter_turn_strobe
// Purpose  : Rising-edge detector on action_en, gated by game_over and dead.
// Revision : 1.0
// ============================================================================
module fighter_turn_strobe (
    input  logic clk,
    input  logic reset,
    input  logic action_en_i,
    input  logic game_over_i,
    input  logic dead_i,
    output logic turn_o
);

    logic prev_en_q;

    // Resetting high means a level already asserted at reset release fires nothing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            prev_en_q <= 1'b1;
        else
            prev_en_q <= action_en_i;
    end

    assign turn_o = action_en_i & ~prev_en_q & ~game_over_i & ~dead_i;

endmodule
`default_nettype wire

// File: rtl/fighter_player.sv
`default_nettype none
// ============================================================================
// Module   : fighter_player
// Purpose  : Per-player turn engine: position, health, hit and clash logic.
//            FIGHTER_REGEN_EN compiles in wait-based health regeneration.
// Revision : 1.0
// ============================================================================
module fighter_player
    import fighter_pkg::*;
#(
    parameter  int NUM_POS     = 3,
    parameter  int HEALTH_W    = 2,
    parameter  int MAX_HEALTH  = 3,
    parameter  int KICK_DMG    = 1,
    parameter  int PUNCH_DMG   = 2,
    parameter  int KICK_RANGE  = 1,
    parameter  int REGEN_WAITS = 2,
    parameter  int SIDE        = 0,
    localparam int POS_W       = (NUM_POS > 1) ? $clog2(NUM_POS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                action_en,
    input  logic                game_over,
    input  logic [ACTION_W-1:0] own_action,
    input  logic [ACTION_W-1:0] opp_action,
    input  logic [POS_W-1:0]    opp_pos,
    output logic [POS_W-1:0]    pos,
    output logic [HEALTH_W-1:0] health,
    output logic                hit,
    output logic                dead
);

    localparam int HOME = home_cell(SIDE, NUM_POS);

    logic [POS_W-1:0]    pos_q, pos_d;
    logic [HEALTH_W-1:0] health_q, health_d;
    logic                hit_q, hit_d;
    logic                w_turn;
    logic                w_regen;
    logic                w_kick_in, w_punch_in, w_clash;
    logic [HEALTH_W:0]   w_h1;
    int                  w_dist;
    int                  w_dmg;

    fighter_turn_strobe u_strobe (
        .clk         (clk),
        .reset       (reset),
        .action_en_i (action_en),
        .game_over_i (game_over),
        .dead_i      (dead),
        .turn_o      (w_turn)
    );

`ifdef FIGHTER_REGEN_EN
    localparam int CNT_W = (REGEN_WAITS > 0) ? $clog2(REGEN_WAITS + 1) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign w_regen = (own_action == ACT_WAIT) && (int'(cnt_q) + 1 == REGEN_WAITS);

    always_comb begin
        cnt_d = cnt_q;
        if (w_turn) begin
            if ((own_action != ACT_WAIT) || w_regen)
                cnt_d = '0;
            else
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
`else
    logic unused_regen;
    assign w_regen      = 1'b0;
    assign unused_regen = (REGEN_WAITS == 0);
`endif

    // All hit tests use pre-move positions.
    always_comb begin
        w_dist     = (int'(pos_q) > int'(opp_pos)) ? int'(pos_q) - int'(opp_pos)
                                                   : int'(opp_pos) - int'(pos_q);
        w_kick_in  = (opp_action == ACT_KICK) && (w_dist <= KICK_RANGE) &&
                     (own_action != ACT_JUMP);
        w_punch_in = (opp_action == ACT_PUNCH) && (w_dist == 0);
        w_clash    = (own_action == opp_action) && (w_kick_in || w_punch_in);

        w_dmg = 0;
        if (!w_clash) begin
            if (w_kick_in)
                w_dmg = KICK_DMG;
            else if (w_punch_in)
                w_dmg = PUNCH_DMG;
        end

        w_h1 = (HEALTH_W + 1)'(sat_sub(int'(health_q), w_dmg));
        if (w_regen && (int'(w_h1) < MAX_HEALTH))
            w_h1 = w_h1 + 1'b1;

        pos_d    = pos_q;
        health_d = health_q;
        hit_d    = 1'b0;

        if (w_turn) begin
            if (w_clash) begin
                pos_d = POS_W'(sat_add(int'(pos_q), (SIDE == 0) ? -1 : 1, NUM_POS));
            end else begin
                case (own_action)
                    ACT_LEFT1:  pos_d = POS_W'(sat_add(int'(pos_q), -1, NUM_POS));
                    ACT_LEFT2:  pos_d = POS_W'(sat_add(int'(pos_q), -2, NUM_POS));
                    ACT_RIGHT1: pos_d = POS_W'(sat_add(int'(pos_q),  1, NUM_POS));
                    ACT_RIGHT2: pos_d = POS_W'(sat_add(int'(pos_q),  2, NUM_POS));
                    default:    pos_d = pos_q;
                endcase
            end
            health_d = w_h1[HEALTH_W-1:0];
            hit_d    = (w_dmg != 0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_q    <= POS_W'(HOME);
            health_q <= HEALTH_W'(MAX_HEALTH);
            hit_q    <= 1'b0;
        end else begin
            pos_q    <= pos_d;
            health_q <= health_d;
            hit_q    <= hit_d;
        end
    end

    assign pos    = pos_q;
    assign health = health_q;
    assign hit    = hit_q;
    assign dead   = (health_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_fighter_player.sv
`default_nettype none
// ============================================================================
// Module   : tb_fighter_player
// Purpose  : Self-checking bench for a left and a right fighter_player.
// Revision : 1.0
// ============================================================================
module tb_fighter_player;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       action_en = 1'b1;
    logic       game_over = 1'b0;
    logic [2:0] own_a [2];
    logic [2:0] opp_a [2];
    logic [1:0] opp_p [2];
    logic [1:0] pos_o [2];
    logic [1:0] health_o [2];
    logic       hit_o [2];
    logic       dead_o [2];

    int n_vec = 0;
    int n_err = 0;

    // Reference state: plain integers per player.
    int m_pos [2];
    int m_h   [2];
    int m_cnt [2];
    bit m_hit [2];
    bit m_prev;

    always #5 clk = ~clk;

    fighter_player #(.SIDE(0)) u_p0 (
        .clk(clk), .reset(reset), .action_en(action_en), .game_over(game_over),
        .own_action(own_a[0]), .opp_action(opp_a[0]), .opp_pos(opp_p[0]),
        .pos(pos_o[0]), .health(health_o[0]), .hit(hit_o[0]), .dead(dead_o[0])
    );

    fighter_player #(.SIDE(1)) u_p1 (
        .clk(clk), .reset(reset), .action_en(action_en), .game_over(game_over),
        .own_action(own_a[1]), .opp_action(opp_a[1]), .opp_pos(opp_p[1]),
        .pos(pos_o[1]), .health(health_o[1]), .hit(hit_o[1]), .dead(dead_o[1])
    );

    function automatic void model_reset();
        m_pos[0] = 0;
        m_pos[1] = 2;
        for (int s = 0; s < 2; s++) begin
            m_h[s]   = 3;
            m_cnt[s] = 0;
            m_hit[s] = 1'b0;
        end
        m_prev = 1'b1;
    endfunction

    function automatic void model_resolve(input int s);
        int own = int'(own_a[s]);
        int opp = int'(opp_a[s]);
        int d   = (m_pos[s] > int'(opp_p[s])) ? m_pos[s] - int'(opp_p[s]) : int'(opp_p[s]) - m_pos[s];
        int dmg = 0;
        int np  = m_pos[s];
        if (opp == 0 && d <= 1 && own != 3) dmg = 1;
        else if (opp == 1 && d == 0)        dmg = 2;
        if (dmg != 0 && own == opp) begin
            dmg = 0;
            np  = (s == 0) ? m_pos[s] - 1 : m_pos[s] + 1;
        end else begin
            case (own)
                4: np = m_pos[s] - 1;
                5: np = m_pos[s] - 2;
                6: np = m_pos[s] + 1;
                7: np = m_pos[s] + 2;
                default: np = m_pos[s];
            endcase
        end
        m_pos[s] = (np < 0) ? 0 : (np > 2) ? 2 : np;
        m_h[s]   = (m_h[s] - dmg < 0) ? 0 : m_h[s] - dmg;
`ifdef FIGHTER_REGEN_EN
        if (own == 2) begin
            m_cnt[s] = m_cnt[s] + 1;
            if (m_cnt[s] == 2) begin
                m_cnt[s] = 0;
                if (m_h[s] < 3) m_h[s] = m_h[s] + 1;
            end
        end else begin
            m_cnt[s] = 0;
        end
`endif
        m_hit[s] = (dmg != 0);
    endfunction

    function automatic void model_step();
        if (!reset) begin
            model_reset();
            return;
        end
        for (int s = 0; s < 2; s++) begin
            m_hit[s] = 1'b0;
            if (action_en && !m_prev && !game_over && m_h[s] != 0)
                model_resolve(s);
        end
        m_prev = action_en;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic turn(input int own, input int opp, input int op);
        action_en = 1'b0;
        tick();
        for (int s = 0; s < 2; s++) begin
            own_a[s] = 3'(own);
            opp_a[s] = 3'(opp);
            opp_p[s] = 2'(op);
        end
        action_en = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        action_en = 1'b1;
        do_reset();
        for (int s = 0; s < 2; s++) begin
            own_a[s] = 3'd4; opp_a[s] = 3'd2; opp_p[s] = 2'd1;
        end
        repeat (3) tick();
        n_vec++; if (pos_o[1] !== 2'd2) begin n_err++; $display("FAIL reset_pos1 got %0d want 2", pos_o[1]); end
        n_vec++; if (pos_o[0] !== 2'd0) begin n_err++; $display("FAIL reset_pos0 got %0d want 0", pos_o[0]); end
        n_vec++; if (health_o[1] !== 2'd3) begin n_err++; $display("FAIL reset_health got %0d want 3", health_o[1]); end
        n_vec++; if (dead_o[1] !== 1'b0 || hit_o[1] !== 1'b0) begin
            n_err++; $display("FAIL reset_flags got dead=%b hit=%b want 0 0", dead_o[1], hit_o[1]);
        end
    endtask

    task automatic test_kick_hit();
        do_reset();
        turn(4, 2, 0);
        turn(2, 0, 2);
        n_vec++; if (health_o[1] !== 2'd2) begin n_err++; $display("FAIL kick_health got %0d want 2", health_o[1]); end
        n_vec++; if (hit_o[1] !== 1'b1) begin n_err++; $display("FAIL kick_hit got %b want 1", hit_o[1]); end
        n_vec++; if (pos_o[1] !== 2'd1) begin n_err++; $display("FAIL kick_pos got %0d want 1", pos_o[1]); end
        tick();
        n_vec++; if (hit_o[1] !== 1'b0 || health_o[1] !== 2'd2) begin
            n_err++; $display("FAIL kick_pulse got hit=%b health=%0d want 0 2", hit_o[1], health_o[1]);
        end
    endtask

    task automatic test_jump();
        do_reset();
        turn(4, 2, 0);
        turn(3, 0, 2);
        n_vec++; if (health_o[1] !== 2'd3 || hit_o[1] !== 1'b0) begin
            n_err++; $display("FAIL jump_evade got health=%0d hit=%b want 3 0", health_o[1], hit_o[1]);
        end
    endtask

    task automatic test_clash();
        do_reset();
        turn(4, 2, 0);
        turn(1, 1, 1);
        n_vec++; if (pos_o[1] !== 2'd2) begin n_err++; $display("FAIL clash_push got %0d want 2", pos_o[1]); end
        n_vec++; if (health_o[1] !== 2'd3 || hit_o[1] !== 1'b0) begin
            n_err++; $display("FAIL clash_nodmg got health=%0d hit=%b want 3 0", health_o[1], hit_o[1]);
        end
        turn(1, 1, 2);
        n_vec++; if (pos_o[1] !== 2'd2) begin n_err++; $display("FAIL clash_sat got %0d want 2", pos_o[1]); end
    endtask

    task automatic test_regen();
        int exp_h [6];
`ifdef FIGHTER_REGEN_EN
        exp_h = '{1, 2, 2, 3, 3, 3};
`else
        exp_h = '{1, 1, 1, 1, 1, 1};
`endif
        do_reset();
        turn(3, 1, 2);
        n_vec++; if (health_o[1] !== 2'd1) begin n_err++; $display("FAIL regen_setup got %0d want 1", health_o[1]); end
        for (int i = 0; i < 6; i++) begin
            turn(2, 2, 0);
            n_vec++; if (health_o[1] !== 2'(exp_h[i])) begin
                n_err++; $display("FAIL regen_wait%0d got %0d want %0d", i + 1, health_o[1], exp_h[i]);
            end
        end
    endtask

    task automatic test_dead();
        do_reset();
        turn(3, 1, 2);
        turn(3, 1, 2);
        n_vec++; if (health_o[1] !== 2'd0 || dead_o[1] !== 1'b1 || hit_o[1] !== 1'b1) begin
            n_err++; $display("FAIL dead_floor got health=%0d dead=%b hit=%b want 0 1 1", health_o[1], dead_o[1], hit_o[1]);
        end
        turn(5, 2, 0);
        n_vec++; if (pos_o[1] !== 2'd2 || dead_o[1] !== 1'b1) begin
            n_err++; $display("FAIL dead_frozen got pos=%0d dead=%b want 2 1", pos_o[1], dead_o[1]);
        end
        // Asynchronous reset between clock edges.
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++; if (health_o[1] !== 2'd3 || dead_o[1] !== 1'b0) begin
            n_err++; $display("FAIL async_reset got health=%0d dead=%b want 3 0", health_o[1], dead_o[1]);
        end
        model_reset();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_held_and_gameover();
        do_reset();
        action_en = 1'b0;
        tick();
        for (int s = 0; s < 2; s++) begin
            own_a[s] = 3'd4; opp_a[s] = 3'd2; opp_p[s] = 2'd0;
        end
        action_en = 1'b1;
        repeat (5) tick();
        n_vec++; if (pos_o[1] !== 2'd1) begin n_err++; $display("FAIL held_single got %0d want 1", pos_o[1]); end
        action_en = 1'b0;
        tick();
        game_over = 1'b1;
        action_en = 1'b1;
        tick();
        game_over = 1'b0;
        repeat (2) tick();
        n_vec++; if (pos_o[1] !== 2'd1) begin n_err++; $display("FAIL gameover_consumed got %0d want 1", pos_o[1]); end
        turn(4, 2, 0);
        n_vec++; if (pos_o[1] !== 2'd0) begin n_err++; $display("FAIL gameover_after got %0d want 0", pos_o[1]); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 40 == 39) do_reset();
            for (int s = 0; s < 2; s++) begin
                own_a[s] = 3'($urandom_range(0, 7));
                opp_a[s] = 3'($urandom_range(0, 7));
                opp_p[s] = 2'($urandom_range(0, 2));
            end
            action_en = 1'($urandom_range(0, 1));
            game_over = ($urandom_range(0, 7) == 0);
            tick();
            for (int s = 0; s < 2; s++) begin
                n_vec++;
                if ({pos_o[s], health_o[s], hit_o[s], dead_o[s]} !==
                    {2'(m_pos[s]), 2'(m_h[s]), m_hit[s], (m_h[s] == 0)}) begin
                    n_err++;
                    $display("FAIL random_p%0d cyc %0d got pos=%0d h=%0d hit=%b dead=%b want pos=%0d h=%0d hit=%b dead=%b",
                             s, i, pos_o[s], health_o[s], hit_o[s], dead_o[s],
                             m_pos[s], m_h[s], m_hit[s], (m_h[s] == 0));
                end
            end
        end
        game_over = 1'b0;
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            own_a[s] = 3'd2; opp_a[s] = 3'd2; opp_p[s] = 2'd0;
        end
        model_reset();
        test_reset();
        test_kick_hit();
        test_jump();
        test_clash();
        test_regen();
        test_dead();
        test_held_and_gameover();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
